// File: rtl/core_pkg.sv
// Shared definitions for the memory port arbiter: default bus widths,
// the default MA burst limit and the read-owner encoding.
package core_pkg;

  // Default memory data and address widths.
  localparam int CORE_DATA_W       = 16;
  localparam int CORE_ADDR_W       = 16;

  // Default number of back-to-back MA grants tolerated while fetch waits.
  localparam int CORE_MAX_MA_BURST = 4;

  // Which requester owns the read data returning from memory next cycle.
  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_MA = 1'b1
  } owner_e;

  // Counter width able to hold every value from 0 up to max_burst.
  function automatic int burst_cnt_w(input int max_burst);
    if (max_burst < 1) begin
      return 1;
    end
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/arb_starve_counter.sv
// Fetch starvation guard: counts consecutive MA grants that were taken while
// fetch was waiting, and raises force_if once the burst limit is reached so
// that the next waiting fetch is served ahead of MA.
module arb_starve_counter
  import core_pkg::*;
#(
  parameter int MAX_MA_BURST = CORE_MAX_MA_BURST
) (
  input  logic clk,
  input  logic rst_n,
  input  logic if_req,
  input  logic if_grant,
  input  logic ma_grant,
  output logic force_if
);

  localparam int                CNT_W = burst_cnt_w(MAX_MA_BURST);
  localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(MAX_MA_BURST);

  logic [CNT_W-1:0] count;

  // Count MA grants while fetch waits; any fetch grant or a fetch that stops
  // asking restarts the burst. The count saturates at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (!if_req || if_grant) begin
      count <= '0;
    end else if (ma_grant && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  assign force_if = if_req && (count == LIMIT);

endmodule

// File: rtl/memory_port_arbiter.sv
// Arbiter sharing one single-port synchronous memory between the instruction
// fetch port (IF) and the memory-access stage port (MA). MA wins by default;
// grants and memory controls are combinational, read data returns to the
// granted owner one cycle later.
// Optional feature: define ARB_STARVE_GUARD_EN to force a fetch grant after
// MAX_MA_BURST consecutive MA grants taken while fetch was waiting.
module memory_port_arbiter
  import core_pkg::*;
#(
  parameter int DATA_W       = CORE_DATA_W,
  parameter int ADDR_W       = CORE_ADDR_W,
  parameter int MAX_MA_BURST = CORE_MAX_MA_BURST
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_grant,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,

  input  logic              ma_req,
  input  logic              ma_we,
  input  logic [ADDR_W-1:0] ma_addr,
  input  logic [DATA_W-1:0] ma_wdata,
  output logic              ma_grant,
  output logic              ma_rvalid,
  output logic [DATA_W-1:0] ma_rdata,

  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic              stall_if
);

  owner_e            owner_q;
  owner_e            owner_d;
  logic              pending_q;
  logic              pending_d;
  logic              force_if;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] ma_rdata_q;

`ifdef ARB_STARVE_GUARD_EN
  arb_starve_counter #(
    .MAX_MA_BURST (MAX_MA_BURST)
  ) u_starve_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_req   (if_req),
    .if_grant (if_grant),
    .ma_grant (ma_grant),
    .force_if (force_if)
  );
`else
  assign force_if = 1'b0;
`endif

  // Pick at most one winner and steer its request onto the memory port;
  // nothing is granted while reset is held.
  always_comb begin
    if_grant  = 1'b0;
    ma_grant  = 1'b0;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (rst_n) begin
      if (ma_req && !force_if) begin
        ma_grant  = 1'b1;
        mem_addr  = ma_addr;
        mem_we    = ma_we;
        mem_wdata = ma_we ? ma_wdata : '0;
      end else if (if_req) begin
        if_grant  = 1'b1;
        mem_addr  = if_addr;
      end
    end
  end

  // Fetch must hold its PC whenever it asks and loses the cycle.
  assign stall_if = rst_n && if_req && !if_grant;

  // Record which port owns the memory read data that returns next cycle;
  // writes never produce returning data.
  always_comb begin
    pending_d = 1'b0;
    owner_d   = owner_q;
    if (ma_grant && !ma_we) begin
      pending_d = 1'b1;
      owner_d   = OWN_MA;
    end else if (if_grant) begin
      pending_d = 1'b1;
      owner_d   = OWN_IF;
    end
  end

  // Owner tag and pending-read flag; reset drops any read in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q   <= OWN_IF;
      pending_q <= 1'b0;
    end else begin
      owner_q   <= owner_d;
      pending_q <= pending_d;
    end
  end

  assign if_rvalid = pending_q && (owner_q == OWN_IF);
  assign ma_rvalid = pending_q && (owner_q == OWN_MA);

  // Remember the last word delivered to each port so a port's read data
  // stays stable while the other port owns the memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rdata_q <= '0;
      ma_rdata_q <= '0;
    end else begin
      if (if_rvalid) begin
        if_rdata_q <= mem_rdata;
      end
      if (ma_rvalid) begin
        ma_rdata_q <= mem_rdata;
      end
    end
  end

  assign if_rdata = if_rvalid ? mem_rdata : if_rdata_q;
  assign ma_rdata = ma_rvalid ? mem_rdata : ma_rdata_q;

endmodule
